// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_stage_pkg;

  typedef logic [31:0] word;

  typedef enum logic {
    BRANCH_DISABLE = 1'b0,
    BRANCH_ENABLE  = 1'b1
  } branch_en_t;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FLUSH = 1'b1
  } fetch_state_t;

  localparam word FETCH_RESET_PC = 32'h0000_0000;

  // Instruction fetches are always word aligned.
  function automatic word word_align(input word addr);
    return addr & ~word'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// Synchronous FIFO with a synchronous flush and an occupancy count.
// The head is read straight from registered storage and reads as zero when empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // A flush wins over a same-cycle pop; the pop is simply absorbed.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !flush));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, credit-limited imem requests, response FIFO to decode,
// and redirect handling that drains stale in-flight responses before refetching.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word RESET_PC        = FETCH_RESET_PC,
  parameter int  FIFO_DEPTH      = 4,
  parameter int  MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  branch_en_t   branch_scs,
  input  word          branch_add_in,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output word          imem_req_addr,
  input  logic         imem_resp_valid,
  input  word          imem_resp_data,
  output logic         if_valid,
  input  logic         if_ready,
  output word          if_instr,
  output word          if_pc,
  output fetch_state_t state_dbg
);

  localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW   = $clog2(FIFO_DEPTH) + 1;
  localparam int SW   = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SUMW = ((OW > FW) ? OW : FW) + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and the payload is stable whenever valid is high.

  word               pc;
  fetch_state_t      state;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     stale_cnt;
  logic [OW-1:0]     redirect_stale;
  logic [FW-1:0]     fifo_count;
  logic [SW-1:0]     side_count;
  logic [SUMW-1:0]   credit_used;
  logic [63:0]       fifo_head;
  word               side_head;
  logic              redirect;
  logic              req_fire;
  logic              resp_keep;
  logic              if_pop;

  assign redirect    = (branch_scs == BRANCH_ENABLE);
  assign credit_used = SUMW'(outstanding) + SUMW'(fifo_count);

  // Credits count every request that could still land in the FIFO, so a push never finds it full.
  assign imem_req_valid = rst_n && (state == FETCH_RUN) && !redirect &&
                          (credit_used < SUMW'(FIFO_DEPTH)) &&
                          (outstanding < OW'(MAX_OUTSTANDING));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses racing a redirect, or owed to a pre-redirect request, never reach decode.
  assign resp_keep      = imem_resp_valid && (stale_cnt == '0) && !redirect;
  assign redirect_stale = outstanding - OW'(imem_resp_valid);

  assign if_valid  = (fifo_count != '0);
  assign if_pop    = if_valid && if_ready;
  assign if_instr  = fifo_head[63:32];
  assign if_pc     = fifo_head[31:0];
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      state       <= FETCH_RUN;
      outstanding <= '0;
      stale_cnt   <= '0;
    end else begin
      outstanding <= outstanding + OW'(req_fire) - OW'(imem_resp_valid);
      if (redirect) begin
        pc        <= word_align(branch_add_in);
        stale_cnt <= redirect_stale;
        state     <= (redirect_stale != '0) ? FETCH_FLUSH : FETCH_RUN;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (imem_resp_valid && (stale_cnt != '0)) stale_cnt <= stale_cnt - OW'(1);
        if ((state == FETCH_FLUSH) &&
            ((stale_cnt == '0) || ((stale_cnt == OW'(1)) && imem_resp_valid)))
          state <= FETCH_RUN;
      end
    end
  end

  // Address of each live request, consumed in order as its response is kept.
  fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (32)
  ) u_side_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (req_fire),
    .push_data (pc),
    .pop       (resp_keep),
    .head      (side_head),
    .count     (side_count)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_instr_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (resp_keep),
    .push_data ({imem_resp_data, side_head}),
    .pop       (if_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  resp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_resp_valid && (outstanding == '0)));

  kept_resp_has_address: assert property (@(posedge clk) disable iff (!rst_n)
    resp_keep |-> (side_count != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-plus-random bench for fetch_stage: an in-order memory model with variable latency
// and a reference that tracks the expected PC stream per redirect epoch.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam word RST_PC = FETCH_RESET_PC;
  localparam int  CREDIT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  branch_en_t   branch_scs;
  word          branch_add_in;
  logic         imem_req_valid;
  logic         imem_req_ready;
  word          imem_req_addr;
  logic         imem_resp_valid;
  word          imem_resp_data;
  logic         if_valid;
  logic         if_ready;
  word          if_instr;
  word          if_pc;
  fetch_state_t state_dbg;

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .branch_scs      (branch_scs),
    .branch_add_in   (branch_add_in),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .state_dbg       (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model state ----------------
  typedef struct {
    word addr;
    int  epoch;
    int  due;
  } mem_req_t;

  mem_req_t memq[$];   // accepted requests awaiting their in-order response
  word      exp_q[$];  // current-epoch requests not yet delivered to decode
  word      got_q[$];  // pcs delivered since the last redirect/reset

  int  checks = 0;
  int  passes = 0;
  int  fails  = 0;
  int  cyc    = 0;
  int  epoch  = 0;
  int  lat    = 1;
  int  pops_total = 0;
  bit  rand_mode = 1'b0;
  bit  drv_req_ready = 1'b0;
  bit  drv_if_ready  = 1'b0;
  word exp_req = RST_PC;
  word last_acc_addr = '0;

  function automatic word instr_of(input word a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic check(input string tag, input word obs, input word exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    @(negedge clk);
    #2;
    rst_n           = 1'b0;
    branch_scs      = BRANCH_DISABLE;
    branch_add_in   = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if_ready        = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'(0));
    check("rst_req_addr",  imem_req_addr, RST_PC);
    check("rst_if_valid",  32'(if_valid), 32'(0));
    check("rst_if_instr",  if_instr, 32'h0);
    check("rst_if_pc",     if_pc, 32'h0);
    check("rst_state",     32'(state_dbg), 32'(FETCH_RUN));
    memq.delete();
    exp_q.delete();
    got_q.delete();
    epoch++;
    exp_req = RST_PC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs mid-cycle, check outputs, then advance the model at the edge.
  task automatic step(input bit redir, input word tgt);
    bit       resp_now;
    bit       acc;
    bit       pop;
    int       stale;
    int       cur_mem;
    int       fifo_occ;
    word      acc_addr;
    word      pop_pc;
    mem_req_t m;
    @(negedge clk);
    if (rand_mode) begin
      drv_req_ready = ($urandom_range(0, 3) != 0);
      drv_if_ready  = ($urandom_range(0, 3) != 0);
      lat           = $urandom_range(1, 4);
    end
    branch_scs      = redir ? BRANCH_ENABLE : BRANCH_DISABLE;
    branch_add_in   = tgt;
    imem_req_ready  = drv_req_ready;
    if_ready        = drv_if_ready;
    resp_now        = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? instr_of(memq[0].addr) : $urandom();
    stale   = 0;
    cur_mem = 0;
    foreach (memq[i]) begin
      if (memq[i].epoch != epoch) stale++;
      else cur_mem++;
    end
    fifo_occ = exp_q.size() - cur_mem;
    #1;
    check("req_valid", 32'(imem_req_valid),
          32'(!redir && (stale == 0) && ((stale + exp_q.size()) < CREDIT)));
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_req);
    check("if_valid", 32'(if_valid), 32'(fifo_occ > 0));
    if (fifo_occ > 0) begin
      check("if_pc", if_pc, exp_q[0]);
      check("if_instr", if_instr, instr_of(exp_q[0]));
    end
    check("state", 32'(state_dbg), (stale > 0) ? 32'(FETCH_FLUSH) : 32'(FETCH_RUN));
    acc      = imem_req_valid && imem_req_ready;
    pop      = if_valid && if_ready;
    acc_addr = imem_req_addr;
    pop_pc   = if_pc;
    @(posedge clk);
    if (pop) begin
      pops_total++;
      got_q.push_back(pop_pc);
      if (exp_q.size() > 0) exp_q.delete(0);
    end
    if (resp_now) memq.delete(0);
    if (acc) begin
      m.addr  = acc_addr;
      m.epoch = epoch;
      m.due   = cyc + lat;
      memq.push_back(m);
      exp_q.push_back(exp_req);
      exp_req       = exp_req + 32'd4;
      last_acc_addr = acc_addr;
    end
    if (redir) begin
      epoch++;
      exp_q.delete();
      got_q.delete();
      exp_req = word_align(tgt);
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int p0;
    rst_n = 1'b0;
    reset_dut();

    // Zero-wait memory, decode always ready: stream from RESET_PC at one per cycle.
    lat = 1;
    drv_req_ready = 1'b1;
    drv_if_ready  = 1'b1;
    run(20);
    check("first_pc_after_reset", got_q[0], RST_PC);
    p0 = pops_total;
    run(10);
    check("steady_throughput", 32'(pops_total - p0), 32'd10);

    // Decode stall: issue stops at the credit limit, then resumes in order.
    drv_if_ready = 1'b0;
    run(10);
    drv_if_ready = 1'b1;
    run(12);

    // Latency 3, two requests in flight, then redirect to 0x100.
    drv_req_ready = 1'b0;
    run(6);
    lat = 3;
    drv_req_ready = 1'b1;
    run(2);
    drv_req_ready = 1'b0;
    check("two_in_flight", 32'(memq.size()), 32'd2);
    step(1'b1, 32'h0000_0100);
    drv_req_ready = 1'b1;
    run(14);
    check("flush_first_pc", got_q[0], 32'h0000_0100);

    // Misaligned target with nothing outstanding.
    lat = 1;
    drv_req_ready = 1'b0;
    run(6);
    drv_req_ready = 1'b1;
    step(1'b1, 32'h0000_0203);
    run(1);
    check("aligned_target_addr", last_acc_addr, 32'h0000_0200);
    run(8);

    // Redirect coinciding with a response and a decode pop.
    run(6);
    step(1'b1, 32'h0000_0300);
    run(10);
    check("redir_resp_pop_first_pc", got_q[0], 32'h0000_0300);

    // Two redirects one cycle apart; only the second stream survives.
    lat = 2;
    run(6);
    step(1'b1, 32'h0000_0040);
    run(1);
    step(1'b1, 32'h0000_0080);
    run(15);
    check("double_redir_first_pc", got_q[0], 32'h0000_0080);

    // PC wrap across 2^32.
    lat = 1;
    step(1'b1, 32'hFFFF_FFF8);
    run(10);
    check("wrap_pc0", got_q[0], 32'hFFFF_FFF8);
    check("wrap_pc2", got_q[2], 32'h0000_0000);

    // Random traffic: ready, latency and redirect targets all randomised.
    rand_mode = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 19) == 0) step(1'b1, $urandom());
      else step(1'b0, '0);
    end

    // Reset in the middle of random traffic, then restart from RESET_PC.
    run(5);
    reset_dut();
    rand_mode     = 1'b0;
    lat           = 1;
    drv_req_ready = 1'b1;
    drv_if_ready  = 1'b1;
    run(10);
    check("restart_pc", got_q[0], RST_PC);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end; it consumes the redirect pair produced by the execute stage (branch_scs / branch_add_out).
- Holds the PC and issues in-order requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small FIFO that feeds decode through a valid/ready handshake.
- On a redirect it flushes the FIFO, discards stale in-flight responses and restarts fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset.
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >= 2).
MAX_OUTSTANDING, 4, maximum accepted-but-unreturned imem requests.

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
branch_scs  input  branch_en_t  BRANCH_ENABLE = redirect this cycle
branch_add_in  input  32 (word)  redirect target
imem_req_valid  output  1  request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  request address (= pc)
imem_resp_valid  input  1  one in-order response per accepted request
imem_resp_data  input  32  instruction word
if_valid  output  1  FIFO head valid to decode
if_ready  input  1  decode accepts head
if_instr  output  32  head instruction
if_pc  output  32  head instruction address

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC; state = RUN.
  - outstanding = 0, stale_cnt = 0, FIFO empty.
  - imem_req_valid = 0, if_valid = 0; if_instr and if_pc = 0.
- FSM states:
  - RUN: normal fetch.
  - FLUSH: waiting for stale responses to drain.
- Request issue:
  - imem_req_valid = (state == RUN) && !redirect && (outstanding + fifo_count) < FIFO_DEPTH && outstanding < MAX_OUTSTANDING.
  - Credit check uses registered counts; no same-cycle pop bypass.
- Request accept: on imem_req_valid && imem_req_ready, the request is accepted, outstanding++, pc <= pc + 4. The PC wraps modulo 2^32.
- Each request records its address in a side queue of MAX_OUTSTANDING entries. That address becomes if_pc when the matching response is pushed.
- Response handling:
  - If stale_cnt > 0, the response is dropped and stale_cnt--.
  - Otherwise, imem_resp_data and the matching address are pushed into the FIFO.
  - outstanding-- in both cases.
- Credit accounting guarantees the FIFO is never full on a push. A push to a full FIFO is an assertion failure.
- imem_resp_valid with outstanding == 0 is a protocol violation and an assertion failure.
- Decode pop: when if_valid && if_ready. if_valid = FIFO not empty; head fields are registered FIFO outputs.
- Redirect (branch_scs == BRANCH_ENABLE in cycle t):
  - pc <= {branch_add_in[31:2], 2'b00}.
  - FIFO cleared at edge t: if_valid = 0 in cycle t+1.
  - Side-queue entries belonging to stale requests are discarded.
  - No request is issued in cycle t.
  - stale_cnt <= outstanding - (resp this cycle ? 1 : 0) + stale_cnt adjustment, so that every pre-redirect request is counted exactly once.
  - Next state = FLUSH if the new stale_cnt > 0, else RUN.
- Redirect while in FLUSH: pc is updated to the new target and stale_cnt is recomputed under the same rule; the later redirect wins.
- FLUSH -> RUN in the cycle after stale_cnt reaches 0. The first request to the target is issued in that RUN cycle.
- Latency:
  - Redirect with nothing outstanding: target request in cycle t+1.
  - Zero-wait memory: response is pushed at the edge after acceptance; if_valid rises one cycle after the response.
- Simultaneous events:
  - Redirect + response in the same cycle: the response is dropped.
  - Redirect + decode pop in the same cycle: the pop completes and the FIFO is then cleared.
  - Push + pop in the same cycle: fifo_count is unchanged.
- Reset mid-operation: all counters are cleared and late memory responses are ignored. The memory model must also be reset.

Decomposition:
- Add to params.sv:
  - fetch_state_t enum {FETCH_RUN, FETCH_FLUSH}.
  - FETCH_RESET_PC constant.
  - Reuse existing word and branch_en_t.
- One sub-module: fetch_fifo, a synchronous FIFO with a synchronous flush input and count output, parameterised on depth and width. Instantiate it twice: instruction+pc FIFO (64 bits) and request-address side queue (32 bits).

Test Plan:
- Reset release, zero-wait memory, if_ready = 1: addresses 0x0, 0x4, 0x8… are issued; decode receives matching if_pc; steady state sustains 1 instruction per cycle.
- if_ready = 0 for 10 cycles: issue stops at outstanding + fifo_count = 4; no FIFO overflow; draining resumes fetch in order with no lost or duplicated pc.
- Memory latency 3 cycles with 2 outstanding requests, then redirect to 0x100: both old responses are dropped; FSM goes to FLUSH; first new request 0x100 follows in the cycle after stale_cnt hits 0; if_pc = 0x100 is the first value delivered.
- Redirect to 0x203: imem_req_addr = 0x200.
- Redirect in the same cycle as a response and a decode pop: the response is not delivered; if_valid = 0 next cycle; the next delivered pc is the target.
- Two redirects 1 cycle apart (0x40, then 0x80): only 0x80-stream instructions are delivered; pc 0xFFFF_FFFC wraps to 0x0.
- Assert rst_n mid-fetch: outputs clear asynchronously; fetch restarts at RESET_PC.
